tbus_arbiter: RTL and testbench
===============================

// Module: tbus_arbiter
// PURPOSE
//  Shares one trinity bus (tbus) slave port between two requesters:
//  m0 = instruction fetch, m1 = mem-stage LSU. Round-robin arbitration,
//  one transaction in flight at a time. Grant is locked from first valid
//  until the slave's operation_done. Read data and done are routed back to
//  the owner only. A watchdog flags a slave that never completes.
// PARAMETERS
//  ADDR_W        64    tbus_index width
//  DATA_W        64    read/write data width; mask width is also DATA_W
//  OPTYPE_W      2     tbus_operation_type width (`TBUS_READ/`TBUS_WRITE encodings)
//  TIMEOUT_CYC   1024  cycles in OUTSTANDING before timeout_err; 0 disables the watchdog
// PORTS
//  clock                  in   1         system clock
//  reset_n                in   1         async active-low reset
//  m{0,1}_index_valid     in   1         requester has a request
//  m{0,1}_index_ready     out  1         slave ready, routed to the granted master only
//  m{0,1}_index           in   ADDR_W    request address
//  m{0,1}_write_data      in   DATA_W    store data
//  m{0,1}_write_mask      in   DATA_W    store byte-lane mask
//  m{0,1}_operation_type  in   OPTYPE_W  read/write
//  m{0,1}_read_data       out  DATA_W    slave read data when owner, else 0
//  m{0,1}_operation_done  out  1         slave done pulse, owner only
//  s_index_valid/index/write_data/write_mask/operation_type  out  -  to slave
//  s_index_ready          in   1         slave accepts request
//  s_read_data            in   DATA_W    slave read data
//  s_operation_done       in   1         slave completion pulse
//  owner                  out  1         current/last granted master
//  busy                   out  1         state != IDLE
//  timeout_err            out  1         sticky watchdog flag
// BEHAVIOUR
//  States: IDLE, PENDING (granted, waiting for ready), OUTSTANDING (fired, waiting for done).
//  IDLE winner (combinational): a lone requester wins. If both request, the
//   winner is ~last_grant. last_grant resets to 1, so m0 wins the first tie.
//  The winner's index/data/mask/type go to s_* in the same cycle; s_index_valid = winner valid.
//   Zero-cycle grant latency. The non-winner sees ready=0 and done=0.
//  IDLE: fire (valid & ready) -> OUTSTANDING; valid & ~ready -> PENDING.
//   In both cases owner <= winner and last_grant <= winner.
//  PENDING: only the owner is muxed. Owner fire -> OUTSTANDING.
//   Owner drops valid (flush) -> IDLE; no transaction is issued and last_grant is kept.
//  OUTSTANDING: s_index_valid = 0, both readies = 0. On s_operation_done,
//   owner's done = 1 and read_data = s_read_data for that cycle, then -> IDLE.
//   The next arbitration happens in the cycle after done, never in the same cycle.
//  fire and s_operation_done in the same cycle: done goes to the winner and
//   the state stays IDLE.
//  s_operation_done in IDLE/PENDING without a fire: ignored, not routed.
//  Watchdog: counter clears on entry to OUTSTANDING and increments each cycle
//   there. Reaching TIMEOUT_CYC sets timeout_err (sticky until reset); the
//   state stays OUTSTANDING.
//  Reset (async, mid-transaction included): state=IDLE, owner=0, last_grant=1,
//   counter=0, timeout_err=0. All m*/s* outputs are 0 while reset_n=0.
//   Any in-flight slave op is abandoned; its late done is ignored.
//  Request fields are passed through unmodified (no width conversion).
// TESTING
//  m1 load alone, ready=1, done 3 cycles later, rdata=64'hDEAD_BEEF ->
//   m1_ready=1 at cycle 0, m1_done=1 at cycle 3 with m1_read_data=64'hDEAD_BEEF, m0 outputs 0.
//  m0 and m1 both valid from reset, done after 1 cycle each ->
//   grants m0, m1, m0, m1 alternating; no back-to-back grant to one master.
//  m1 store, ready low 4 cycles, m0 asserts valid meanwhile ->
//   s_* stays on m1 index/mask for all 4 cycles; m0 is served only after m1's done.
//  m0 valid in IDLE with ready=1 and done=1 same cycle ->
//   m0_done=1 that cycle, busy stays 0.
//  TIMEOUT_CYC=8, fire with no done -> timeout_err=1 at the 8th cycle in
//   OUTSTANDING; reset_n low -> IDLE, timeout_err=0, a later done is ignored.
//  PENDING owner drops valid -> IDLE next cycle; the other master wins on its next request.

Source files
------------

// File: rtl/tbus_arbiter_if.sv
// Trinity bus channel: request fields flow master->slave; ready, read data
// and the completion pulse flow slave->master.
interface tbus_arbiter_if #(
   parameter int ADDR_W   = 64,
   parameter int DATA_W   = 64,
   parameter int OPTYPE_W = 2
);
   logic                index_valid;
   logic                index_ready;
   logic [ADDR_W-1:0]   index;
   logic [DATA_W-1:0]   write_data;
   logic [DATA_W-1:0]   write_mask;
   logic [OPTYPE_W-1:0] operation_type;
   logic [DATA_W-1:0]   read_data;
   logic                operation_done;

   modport master (
      output index_valid, index, write_data, write_mask, operation_type,
      input  index_ready, read_data, operation_done
   );

   modport slave (
      input  index_valid, index, write_data, write_mask, operation_type,
      output index_ready, read_data, operation_done
   );
endinterface

// File: rtl/tbus_arbiter.sv
// Round-robin arbiter sharing one tbus slave between instruction fetch (m0)
// and the LSU (m1); one transaction in flight, with a completion watchdog.
module tbus_arbiter #(
   parameter int ADDR_W      = 64,
   parameter int DATA_W      = 64,
   parameter int OPTYPE_W    = 2,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic           clock,
   input  logic           reset_n,
   tbus_arbiter_if.slave  m0,
   tbus_arbiter_if.slave  m1,
   tbus_arbiter_if.master s,
   output logic           owner,
   output logic           busy,
   output logic           timeout_err
);
   localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

   typedef enum logic [1:0] {
      ST_IDLE        = 2'd0,
      ST_PENDING     = 2'd1,
      ST_OUTSTANDING = 2'd2
   } state_t;

   state_t              state_r;
   logic                owner_r;
   logic                last_grant_r;
   logic                busy_r;
   logic                timeout_err_r;
   logic [CNT_W-1:0]    wdg_cnt_r;

   logic                sel_s;
   logic                sel_valid_s;
   logic [ADDR_W-1:0]   sel_index_s;
   logic [DATA_W-1:0]   sel_wdata_s;
   logic [DATA_W-1:0]   sel_wmask_s;
   logic [OPTYPE_W-1:0] sel_optype_s;
   logic                fire_s;
   logic                ready_route_s;
   logic                done_route_s;
   logic                wdg_run_s;
   logic                wdg_hit_s;

   // Requester selection: arbitrate only in IDLE, otherwise stay locked on the owner
   always_comb begin
      sel_s = owner_r;
      if (state_r == ST_IDLE) begin
         if (m0.index_valid && m1.index_valid) begin
            sel_s = ~last_grant_r;
         end else begin
            sel_s = m1.index_valid;
         end
      end else begin
         sel_s = owner_r;
      end
   end

   // Request field mux and handshake routing toward the selected requester
   always_comb begin
      sel_valid_s  = m0.index_valid;
      sel_index_s  = m0.index;
      sel_wdata_s  = m0.write_data;
      sel_wmask_s  = m0.write_mask;
      sel_optype_s = m0.operation_type;
      if (sel_s) begin
         sel_valid_s  = m1.index_valid;
         sel_index_s  = m1.index;
         sel_wdata_s  = m1.write_data;
         sel_wmask_s  = m1.write_mask;
         sel_optype_s = m1.operation_type;
      end else begin
         sel_valid_s  = m0.index_valid;
      end
      fire_s        = (state_r != ST_OUTSTANDING) && sel_valid_s && s.index_ready;
      ready_route_s = s.index_ready &&
                      ((state_r == ST_PENDING) || ((state_r == ST_IDLE) && sel_valid_s));
      done_route_s  = s.operation_done && ((state_r == ST_OUTSTANDING) || fire_s);
   end

   // Watchdog: the flag becomes visible during the TIMEOUT_CYC-th OUTSTANDING cycle
   always_comb begin
      wdg_run_s = (state_r == ST_OUTSTANDING) && (int'(wdg_cnt_r) < TIMEOUT_CYC);
      wdg_hit_s = 1'b0;
      if (TIMEOUT_CYC == 1) begin
         wdg_hit_s = fire_s && !s.operation_done;
      end else if (TIMEOUT_CYC > 1) begin
         wdg_hit_s = (state_r == ST_OUTSTANDING) && !s.operation_done &&
                     ((int'(wdg_cnt_r) + 32'sd2) == TIMEOUT_CYC);
      end else begin
         wdg_hit_s = 1'b0;
      end
   end

   // Transaction FSM with owner, round-robin history, busy and watchdog state
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_r       <= ST_IDLE;
         owner_r       <= 1'b0;
         last_grant_r  <= 1'b1;
         busy_r        <= 1'b0;
         timeout_err_r <= 1'b0;
         wdg_cnt_r     <= {CNT_W{1'b0}};
      end else begin
         if (wdg_hit_s) begin
            timeout_err_r <= 1'b1;
         end
         case (state_r)
            ST_IDLE: begin
               if (sel_valid_s) begin
                  owner_r      <= sel_s;
                  last_grant_r <= sel_s;
                  if (fire_s && s.operation_done) begin
                     state_r <= ST_IDLE;
                     busy_r  <= 1'b0;
                  end else if (fire_s) begin
                     state_r   <= ST_OUTSTANDING;
                     busy_r    <= 1'b1;
                     wdg_cnt_r <= {CNT_W{1'b0}};
                  end else begin
                     state_r <= ST_PENDING;
                     busy_r  <= 1'b1;
                  end
               end
            end
            ST_PENDING: begin
               if (fire_s && s.operation_done) begin
                  state_r <= ST_IDLE;
                  busy_r  <= 1'b0;
               end else if (fire_s) begin
                  state_r   <= ST_OUTSTANDING;
                  wdg_cnt_r <= {CNT_W{1'b0}};
               end else if (!sel_valid_s) begin
                  state_r <= ST_IDLE;
                  busy_r  <= 1'b0;
               end
            end
            ST_OUTSTANDING: begin
               if (s.operation_done) begin
                  state_r <= ST_IDLE;
                  busy_r  <= 1'b0;
               end else if (wdg_run_s) begin
                  wdg_cnt_r <= wdg_cnt_r + CNT_W'(1);
               end
            end
            default: begin
               state_r <= ST_IDLE;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   // Everything toward the masters and the slave is forced low while in reset
   assign s.index_valid     = reset_n && (state_r != ST_OUTSTANDING) && sel_valid_s;
   assign s.index           = reset_n ? sel_index_s  : {ADDR_W{1'b0}};
   assign s.write_data      = reset_n ? sel_wdata_s  : {DATA_W{1'b0}};
   assign s.write_mask      = reset_n ? sel_wmask_s  : {DATA_W{1'b0}};
   assign s.operation_type  = reset_n ? sel_optype_s : {OPTYPE_W{1'b0}};
   assign m0.index_ready    = reset_n && ready_route_s && !sel_s;
   assign m1.index_ready    = reset_n && ready_route_s && sel_s;
   assign m0.operation_done = reset_n && done_route_s && !sel_s;
   assign m1.operation_done = reset_n && done_route_s && sel_s;
   assign m0.read_data      = (reset_n && done_route_s && !sel_s) ? s.read_data : {DATA_W{1'b0}};
   assign m1.read_data      = (reset_n && done_route_s && sel_s)  ? s.read_data : {DATA_W{1'b0}};
   assign owner             = owner_r;
   assign busy              = busy_r;
   assign timeout_err       = timeout_err_r;
endmodule

// File: tb/tb_tbus_arbiter.sv
// Scoreboard bench for tbus_arbiter: directed scenarios, then randomized
// masters and slave checked against a transaction-level arbitration model.
module tb_tbus_arbiter;
   localparam int AW = 64;
   localparam int DW = 64;
   localparam int OW = 2;
   localparam int TO = 8;
   localparam logic [1:0] OP_READ  = 2'd0;
   localparam logic [1:0] OP_WRITE = 2'd1;

   logic clock = 1'b0;
   logic reset_n;
   logic owner, busy, timeout_err;

   tbus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .OPTYPE_W(OW)) m0_bus ();
   tbus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .OPTYPE_W(OW)) m1_bus ();
   tbus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .OPTYPE_W(OW)) s_bus ();

   tbus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .OPTYPE_W(OW), .TIMEOUT_CYC(TO)) dut (
      .clock(clock), .reset_n(reset_n),
      .m0(m0_bus), .m1(m1_bus), .s(s_bus),
      .owner(owner), .busy(busy), .timeout_err(timeout_err)
   );

   always #5 clock = ~clock;

   int errors = 0;
   int checks = 0;

   // transaction-level model: 0 bus free, 1 claimed by mdl_own, 2 op in flight
   int  mdl_st   = 0;
   bit  mdl_own  = 1'b0;
   bit  mdl_last = 1'b1;
   bit  sb_q[$];
   bit  mf[2];
   bit  s_fired  = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_step();
      bit v0, v1, rdy, dn, got0, got1, w, wv, fire, exp_done, exp_m;
      v0   = m0_bus.index_valid;
      v1   = m1_bus.index_valid;
      rdy  = s_bus.index_ready;
      dn   = s_bus.operation_done;
      got0 = m0_bus.operation_done;
      got1 = m1_bus.operation_done;
      mf[0]   = v0 & m0_bus.index_ready;
      mf[1]   = v1 & m1_bus.index_ready;
      s_fired = s_bus.index_valid & rdy;
      fire = 1'b0;
      case (mdl_st)
         0:       begin w = (v0 && v1) ? ~mdl_last : v1; wv = v0 | v1; end
         1:       begin w = mdl_own; wv = w ? v1 : v0; end
         default: begin w = mdl_own; wv = 1'b0; end
      endcase
      chk("busy", busy, (mdl_st != 0));
      chk("owner", owner, mdl_own);
      chk("s_valid", s_bus.index_valid, wv);
      if (wv) begin
         chk("s_index", s_bus.index, w ? m1_bus.index : m0_bus.index);
         chk("s_wdata", s_bus.write_data, w ? m1_bus.write_data : m0_bus.write_data);
         chk("s_wmask", s_bus.write_mask, w ? m1_bus.write_mask : m0_bus.write_mask);
         chk("s_optype", s_bus.operation_type, w ? m1_bus.operation_type : m0_bus.operation_type);
         chk("ready_route", {m1_bus.index_ready, m0_bus.index_ready}, w ? {rdy, 1'b0} : {1'b0, rdy});
         fire = rdy;
      end else if (mdl_st == 2) begin
         chk("ready_blocked", {m1_bus.index_ready, m0_bus.index_ready}, 2'b00);
      end
      if (fire) sb_q.push_back(w);
      exp_done = dn && ((mdl_st == 2) || fire);
      chk("done_route", {got1, got0}, exp_done ? (w ? 2'b10 : 2'b01) : 2'b00);
      if (got0 || got1) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL done_unexpected: actual=%b%b required=none", got1, got0);
         end else begin
            exp_m = sb_q.pop_front();
            chk("done_owner", got1, exp_m);
            chk("rdata_owner", got1 ? m1_bus.read_data : m0_bus.read_data, s_bus.read_data);
         end
      end
      if (!got0) chk("rdata0_zero", m0_bus.read_data, 64'd0);
      if (!got1) chk("rdata1_zero", m1_bus.read_data, 64'd0);
      case (mdl_st)
         0: if (wv) begin
               mdl_own  = w;
               mdl_last = w;
               mdl_st   = fire ? (dn ? 0 : 2) : 1;
            end
         1: if (!wv) mdl_st = 0;
            else if (fire) mdl_st = dn ? 0 : 2;
         default: if (dn) mdl_st = 0;
      endcase
   endtask

   // monitor: checks every cycle on the falling edge
   initial forever begin
      @(negedge clock);
      if (!reset_n) begin
         chk("reset_outputs", {s_bus.index_valid, m0_bus.index_ready, m1_bus.index_ready,
                               m0_bus.operation_done, m1_bus.operation_done, owner, busy,
                               timeout_err, |s_bus.index, |s_bus.write_mask,
                               |m0_bus.read_data, |m1_bus.read_data}, 64'd0);
         mdl_st   = 0;
         mdl_own  = 1'b0;
         mdl_last = 1'b1;
         sb_q.delete();
         mf[0]    = 1'b0;
         mf[1]    = 1'b0;
         s_fired  = 1'b0;
      end else begin
         model_step();
      end
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: actual=running required=finished");
      $fatal(1, "bench time limit");
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      m0_bus.index_valid = 1'b0; m0_bus.index = 64'd0; m0_bus.write_data = 64'd0;
      m0_bus.write_mask = 64'd0; m0_bus.operation_type = OP_READ;
      m1_bus.index_valid = 1'b0; m1_bus.index = 64'd0; m1_bus.write_data = 64'd0;
      m1_bus.write_mask = 64'd0; m1_bus.operation_type = OP_READ;
      s_bus.index_ready = 1'b0; s_bus.read_data = 64'd0; s_bus.operation_done = 1'b0;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      repeat (2) tick();
      reset_n = 1'b1;
   endtask

   logic       rv[2];
   logic [63:0] ridx[2], rwd[2], rwm[2];
   logic [1:0] rty[2];
   bit         sbusy;
   int         scnt;

   initial begin
      idle_inputs();
      reset_n = 1'b1;
      #1 reset_n = 1'b0;
      repeat (3) tick();
      reset_n = 1'b1;
      chk("reset_timeout", timeout_err, 1'b0);

      // m1 load alone, done three cycles after the grant
      m1_bus.index_valid = 1'b1; m1_bus.index = 64'h1000; m1_bus.operation_type = OP_READ;
      s_bus.index_ready = 1'b1;
      @(negedge clock);
      chk("t1_m1_ready_c0", m1_bus.index_ready, 1'b1);
      chk("t1_m0_ready_c0", m0_bus.index_ready, 1'b0);
      tick(); m1_bus.index_valid = 1'b0; s_bus.index_ready = 1'b0;
      tick();
      tick(); s_bus.operation_done = 1'b1; s_bus.read_data = 64'hDEAD_BEEF;
      @(negedge clock);
      chk("t1_m1_done_c3", m1_bus.operation_done, 1'b1);
      chk("t1_m1_rdata", m1_bus.read_data, 64'hDEAD_BEEF);
      chk("t1_m0_quiet", {m0_bus.operation_done, m0_bus.read_data}, 64'd0);
      tick(); idle_inputs();

      // both masters requesting continuously: strict alternation starting with m0
      do_reset();
      for (int k = 0; k < 4; k++) begin
         m0_bus.index_valid = 1'b1; m0_bus.index = 64'hA0 + 64'(k);
         m1_bus.index_valid = 1'b1; m1_bus.index = 64'hB0 + 64'(k);
         m1_bus.operation_type = OP_WRITE; m1_bus.write_data = 64'(k) * 64'h11;
         s_bus.index_ready = 1'b1; s_bus.operation_done = 1'b0;
         @(negedge clock);
         chk("t2_grant", {m1_bus.index_ready, m0_bus.index_ready}, (k % 2 == 1) ? 2'b10 : 2'b01);
         tick(); s_bus.index_ready = 1'b0; s_bus.operation_done = 1'b1; s_bus.read_data = 64'h700 + 64'(k);
         @(negedge clock);
         chk("t2_done", {m1_bus.operation_done, m0_bus.operation_done}, (k % 2 == 1) ? 2'b10 : 2'b01);
         tick(); s_bus.operation_done = 1'b0;
      end
      idle_inputs();
      tick();

      // m1 store held off by the slave while m0 waits
      m1_bus.index_valid = 1'b1; m1_bus.index = 64'hC0FFEE; m1_bus.write_mask = 64'h00FF;
      m1_bus.write_data = 64'h1234_5678; m1_bus.operation_type = OP_WRITE;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         chk("t3_s_index_hold", s_bus.index, 64'hC0FFEE);
         chk("t3_s_mask_hold", s_bus.write_mask, 64'h00FF);
         chk("t3_m0_blocked", m0_bus.index_ready, 1'b0);
         tick();
         m0_bus.index_valid = 1'b1; m0_bus.index = 64'h5555;
      end
      s_bus.index_ready = 1'b1;
      @(negedge clock);
      chk("t3_m1_fire", {m1_bus.index_ready, m0_bus.index_ready}, 2'b10);
      tick(); m1_bus.index_valid = 1'b0; s_bus.index_ready = 1'b0; s_bus.operation_done = 1'b1;
      s_bus.read_data = 64'hABCD;
      @(negedge clock);
      chk("t3_m1_done", {m1_bus.operation_done, m0_bus.operation_done}, 2'b10);
      tick(); s_bus.operation_done = 1'b0; s_bus.index_ready = 1'b1;
      @(negedge clock);
      chk("t3_m0_served", {m1_bus.index_ready, m0_bus.index_ready}, 2'b01);
      tick(); m0_bus.index_valid = 1'b0; s_bus.index_ready = 1'b0; s_bus.operation_done = 1'b1;
      @(negedge clock);
      chk("t3_m0_done", m0_bus.operation_done, 1'b1);
      tick(); idle_inputs();

      // grant, accept and complete in one IDLE cycle
      m0_bus.index_valid = 1'b1; m0_bus.index = 64'h4040;
      s_bus.index_ready = 1'b1; s_bus.operation_done = 1'b1; s_bus.read_data = 64'h1234;
      @(negedge clock);
      chk("t4_m0_done_same", m0_bus.operation_done, 1'b1);
      chk("t4_m0_rdata", m0_bus.read_data, 64'h1234);
      tick(); idle_inputs();
      @(negedge clock);
      chk("t4_busy_low", busy, 1'b0);

      // PENDING owner withdraws; the other master then wins the tie
      tick();
      m0_bus.index_valid = 1'b1; m0_bus.index = 64'h6060;
      tick(); m0_bus.index_valid = 1'b0;
      @(negedge clock);
      chk("t6_pending_busy", busy, 1'b1);
      tick();
      @(negedge clock);
      chk("t6_idle_after_flush", busy, 1'b0);
      tick();
      m0_bus.index_valid = 1'b1; m1_bus.index_valid = 1'b1; m1_bus.index = 64'h7070;
      s_bus.index_ready = 1'b1;
      @(negedge clock);
      chk("t6_other_wins", {m1_bus.index_ready, m0_bus.index_ready}, 2'b10);
      tick(); idle_inputs(); s_bus.operation_done = 1'b1;
      @(negedge clock);
      chk("t6_m1_done", m1_bus.operation_done, 1'b1);
      tick(); idle_inputs();

      // watchdog: slave never completes
      m0_bus.index_valid = 1'b1; m0_bus.index = 64'h8080; s_bus.index_ready = 1'b1;
      tick(); idle_inputs();
      for (int c = 1; c <= 9; c++) begin
         @(negedge clock);
         chk("t5_timeout_cycle", timeout_err, (c >= TO) ? 1'b1 : 1'b0);
         tick();
      end
      #2 reset_n = 1'b0;
      @(negedge clock);
      chk("t5_reset_clears_err", timeout_err, 1'b0);
      tick(); tick();
      reset_n = 1'b1;
      tick(); s_bus.operation_done = 1'b1; s_bus.read_data = 64'hBAD;
      @(negedge clock);
      chk("t5_late_done_ignored", {m1_bus.operation_done, m0_bus.operation_done}, 2'b00);
      chk("t5_idle", busy, 1'b0);
      tick(); idle_inputs();
      tick();

      // randomized traffic with a mid-run reset
      for (int m = 0; m < 2; m++) begin
         rv[m] = 1'b0; ridx[m] = 64'd0; rwd[m] = 64'd0; rwm[m] = 64'd0; rty[m] = OP_READ;
      end
      sbusy = 1'b0;
      scnt  = 0;
      for (int cyc = 0; cyc < 3010; cyc++) begin
         tick();
         for (int m = 0; m < 2; m++) begin
            if (mf[m]) rv[m] = 1'b0;
            if (cyc >= 2990) begin
               rv[m] = 1'b0;
            end else if (rv[m] && $urandom_range(0, 15) == 0) begin
               rv[m] = 1'b0;
            end else if (!rv[m] && $urandom_range(0, 2) == 0) begin
               rv[m]   = 1'b1;
               ridx[m] = {$urandom, $urandom};
               rwd[m]  = {$urandom, $urandom};
               rwm[m]  = {$urandom, $urandom};
               rty[m]  = 2'($urandom_range(0, 1));
            end
         end
         m0_bus.index_valid = rv[0]; m0_bus.index = ridx[0]; m0_bus.write_data = rwd[0];
         m0_bus.write_mask = rwm[0]; m0_bus.operation_type = rty[0];
         m1_bus.index_valid = rv[1]; m1_bus.index = ridx[1]; m1_bus.write_data = rwd[1];
         m1_bus.write_mask = rwm[1]; m1_bus.operation_type = rty[1];
         if (s_fired) begin
            sbusy = 1'b1;
            scnt  = $urandom_range(1, 3);
         end
         s_bus.operation_done = 1'b0;
         s_bus.read_data      = {$urandom, $urandom};
         if (sbusy) begin
            if (scnt == 1) begin
               s_bus.operation_done = 1'b1;
               sbusy = 1'b0;
            end else begin
               scnt--;
            end
         end
         s_bus.index_ready = ($urandom_range(0, 2) != 0);
         if (cyc == 1500) #2 reset_n = 1'b0;
         if (cyc == 1503) #2 reset_n = 1'b1;
      end
      idle_inputs();
      tick();
      @(negedge clock);
      chk("final_sb_empty", sb_q.size(), 64'd0);
      chk("final_timeout_clear", timeout_err, 1'b0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
